// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, PC step, opcode field
// position, fetch FSM states and the IF/ID entry layout.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    BLOCKED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_entry_t;

  // An empty slot always shows a NOP so a missed valid gate stays harmless.
  localparam ifid_entry_t IFID_EMPTY = '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0};

  // Instruction addresses are word aligned; the two low bits are dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus: address/request from the fetch stage,
// ready/read data back from memory (data valid in the accepting cycle).
interface if_fetch_stage_if;

  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_skid_buf.sv
// One-entry skid buffer holding a fetched {valid, instr, pc4} while the
// IF/ID register is stalled. Used only when IF_SKID_EN is defined.
module if_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  ifid_entry_t din,
  output ifid_entry_t dout,
  output logic        full
);

  ifid_entry_t entry;

  // Capture a word on load; empty on drain, clear (redirect) or reset.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      entry <= IFID_EMPTY;
    end else if (load) begin
      entry <= din;
    end else if (drain) begin
      entry <= IFID_EMPTY;
    end
  end

  assign dout = entry;
  assign full = entry.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over the imem
// req/ready bus and loads the IF/ID register. Redirects flush and refetch,
// stalls hold IF/ID and PC.
// Build option: define IF_SKID_EN to add a one-entry skid buffer that keeps
// fetching through a stall and resumes without a bubble.
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_stage_if.master       imem,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   ifid_valid,
  output logic [31:0]            ifid_instr,
  output logic [31:0]            ifid_pc4,
  output logic [5:0]             ifid_opcode
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  ifid_entry_t  ifid_q;
  ifid_entry_t  ifid_d;
  ifid_entry_t  fetched;
  logic         req;
  logic         accept;

`ifdef IF_SKID_EN
  logic         skid_load;
  logic         skid_drain;
  logic         skid_clear;
  logic         skid_full;
  ifid_entry_t  skid_out;

  if_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .drain (skid_drain),
    .clear (skid_clear),
    .din   (fetched),
    .dout  (skid_out),
    .full  (skid_full)
  );
`endif

  assign fetched = '{valid: 1'b1, instr: imem.imem_rdata, pc4: pc_q + PC_STEP};
  assign accept  = req & imem.imem_ready;

  // Fetch FSM state register; reset forces BOOT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect wins over stall, BLOCKED only once nothing more fits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          state_d = FETCH;
        end else if (stall) begin
`ifdef IF_SKID_EN
          if (accept || skid_full) begin
            state_d = BLOCKED;
          end
`else
          if (ifid_q.valid) begin
            state_d = BLOCKED;
          end
`endif
        end
      end
      BLOCKED: begin
        if (redirect || !stall) begin
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Request only while fetching and the accepted word has somewhere to go.
  always_comb begin
    req = 1'b0;
    if (state_q == FETCH) begin
`ifdef IF_SKID_EN
      req = !skid_full;
`else
      req = !(stall && ifid_q.valid);
`endif
    end
  end

  // Choose next PC and IF/ID contents (and skid control) for this cycle.
  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
`ifdef IF_SKID_EN
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
`endif
    if (state_q == BOOT) begin
      pc_d = pc_q;
    end else if (redirect) begin
      pc_d   = align_word(redirect_pc);
      ifid_d = IFID_EMPTY;
`ifdef IF_SKID_EN
      skid_clear = 1'b1;
`endif
    end else if (state_q == BLOCKED) begin
      if (!stall) begin
`ifdef IF_SKID_EN
        if (skid_full) begin
          ifid_d     = skid_out;
          skid_drain = 1'b1;
        end else begin
          ifid_d = IFID_EMPTY;
        end
`else
        ifid_d = IFID_EMPTY;
`endif
      end
    end else begin
      if (!stall) begin
`ifdef IF_SKID_EN
        if (skid_full) begin
          ifid_d     = skid_out;
          skid_drain = 1'b1;
        end else if (accept) begin
          ifid_d = fetched;
          pc_d   = pc_q + PC_STEP;
        end else begin
          ifid_d = IFID_EMPTY;
        end
`else
        if (accept) begin
          ifid_d = fetched;
          pc_d   = pc_q + PC_STEP;
        end else begin
          ifid_d = IFID_EMPTY;
        end
`endif
      end else begin
`ifdef IF_SKID_EN
        if (accept) begin
          skid_load = 1'b1;
          pc_d      = pc_q + PC_STEP;
        end
`else
        pc_d = pc_q;
`endif
      end
    end
  end

  // PC and IF/ID registers; reset loads PC_RESET and an empty IF/ID.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= PC_RESET;
      ifid_q <= IFID_EMPTY;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = req;
  assign ifid_valid     = ifid_q.valid;
  assign ifid_instr     = ifid_q.instr;
  assign ifid_pc4       = ifid_q.pc4;
  assign ifid_opcode    = ifid_q.instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready_drv = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_blocked;
  bit          m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic [63:0] skidq[$];

  // Instruction memory contents: a hash of the address so words are distinct.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  if_fetch_stage_if bus();
  assign bus.imem_ready = ready_drv;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  if_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_opcode (ifid_opcode)
  );

  always #5 clk = ~clk;

  // Expected request: not while booting or blocked; otherwise only if the
  // word about to be accepted has a free destination.
  function automatic bit model_req();
    if (m_boot || m_blocked) return 1'b0;
`ifdef IF_SKID_EN
    return skidq.size() == 0;
`else
    return !(stall && m_v);
`endif
  endfunction

  // One clock edge of the fetch rules, in priority order.
  task automatic model_step();
    bit acc;
    logic [63:0] e;
    if (rst) begin
      m_pc = 32'h0; m_boot = 1'b1; m_blocked = 1'b0;
      m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      skidq.delete();
      return;
    end
    if (m_boot) begin
      m_boot = 1'b0;
      return;
    end
    acc = model_req() && ready_drv;
    if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_blocked = 1'b0;
      skidq.delete();
      return;
    end
    if (m_blocked) begin
      if (!stall) begin
        m_blocked = 1'b0;
        if (skidq.size() > 0) begin
          e = skidq.pop_front();
          m_v = 1'b1; m_instr = e[63:32]; m_pc4 = e[31:0];
        end else begin
          m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
        end
      end
      return;
    end
    if (!stall) begin
      if (skidq.size() > 0) begin
        e = skidq.pop_front();
        m_v = 1'b1; m_instr = e[63:32]; m_pc4 = e[31:0];
      end else if (acc) begin
        m_v = 1'b1; m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end else begin
        m_v = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0;
      end
    end else begin
`ifdef IF_SKID_EN
      if (acc) begin
        skidq.push_back({mem_word(m_pc), m_pc + 32'd4});
        m_pc = m_pc + 32'd4;
        m_blocked = 1'b1;
      end else if (skidq.size() > 0) begin
        m_blocked = 1'b1;
      end
`else
      if (m_v) m_blocked = 1'b1;
`endif
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic st,
                       input logic rd, input logic [31:0] rpc);
    rst = r; ready_drv = rdy; stall = st; redirect = rd; redirect_pc = rpc;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Reset (with a competing redirect and stall) gives all reset values.
  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h80);
    advance();
    advance();
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected %h", bus.imem_addr, 32'h0); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", ifid_instr); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc4: got %h expected 0", ifid_pc4); end
    checks++; if (ifid_opcode !== 6'h0) begin errors++; $display("[TB] FAIL reset_opcode: got %h expected 0", ifid_opcode); end
  endtask

  // Ready held high: one instruction per cycle at 0,4,8,...
  task automatic test_sequential();
    logic [31:0] ea;
    logic [31:0] ei;
    do_reset();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL seq_boot_req: got %b expected 0", bus.imem_req); end
    advance();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL seq_first_req: got %b expected 1", bus.imem_req); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_first_valid: got %b expected 0", ifid_valid); end
    advance();
    for (int k = 1; k <= 5; k++) begin
      ea = 32'(4 * k);
      ei = mem_word(32'(4 * (k - 1)));
      @(negedge clk);
      checks++; if (bus.imem_addr !== ea) begin errors++; $display("[TB] FAIL seq_addr: got %h expected %h", bus.imem_addr, ea); end
      checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== ea) begin errors++; $display("[TB] FAIL seq_ifid: got v=%b pc4=%h expected v=1 pc4=%h", ifid_valid, ifid_pc4, ea); end
      checks++; if (ifid_instr !== ei) begin errors++; $display("[TB] FAIL seq_instr: got %h expected %h", ifid_instr, ei); end
      advance();
    end
  endtask

  // Ready low for three cycles at address 8.
  task automatic test_ready_low();
    logic [31:0] ei;
    do_reset();
    advance();
    advance();
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL rdy_addr_hold: got %h expected 8", bus.imem_addr); end
      if (i > 0) begin
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL rdy_bubble: got %b expected 0", ifid_valid); end
      end
      advance();
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b0 || bus.imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL rdy_third_bubble: got v=%b addr=%h expected v=0 addr=8", ifid_valid, bus.imem_addr); end
    advance();
    ei = mem_word(32'h8);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'hC || ifid_instr !== ei) begin errors++; $display("[TB] FAIL rdy_resume: got v=%b pc4=%h instr=%h expected v=1 pc4=c instr=%h", ifid_valid, ifid_pc4, ifid_instr, ei); end
    checks++; if (ifid_opcode !== ei[31:26]) begin errors++; $display("[TB] FAIL rdy_opcode: got %h expected %h", ifid_opcode, ei[31:26]); end
  endtask

  // Two-cycle stall while IF/ID holds the instruction at 4.
  task automatic test_stall();
    logic [31:0] ei;
    do_reset();
    advance();
    advance();
    advance();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
`ifdef IF_SKID_EN
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_skid_req: got %b expected 1", bus.imem_req); end
`else
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", bus.imem_req); end
`endif
    advance();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req2: got %b expected 0", bus.imem_req); end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h8) begin errors++; $display("[TB] FAIL stall_hold: got v=%b pc4=%h expected v=1 pc4=8", ifid_valid, ifid_pc4); end
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h8) begin errors++; $display("[TB] FAIL stall_hold2: got v=%b pc4=%h expected v=1 pc4=8", ifid_valid, ifid_pc4); end
    advance();
    ei = mem_word(32'h8);
    @(negedge clk);
`ifdef IF_SKID_EN
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'hC || ifid_instr !== ei) begin errors++; $display("[TB] FAIL stall_skid_drain: got v=%b pc4=%h expected v=1 pc4=c", ifid_valid, ifid_pc4); end
    advance();
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h10) begin errors++; $display("[TB] FAIL stall_skid_next: got v=%b pc4=%h expected v=1 pc4=10", ifid_valid, ifid_pc4); end
`else
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL stall_bubble: got v=%b instr=%h expected v=0 instr=0", ifid_valid, ifid_instr); end
    advance();
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'hC || ifid_instr !== ei) begin errors++; $display("[TB] FAIL stall_resume: got v=%b pc4=%h expected v=1 pc4=c", ifid_valid, ifid_pc4); end
`endif
  endtask

  // Redirect with stall and a same-cycle accept: word dropped, refetch at 0x40.
  task automatic test_redirect();
    logic [31:0] ei;
    do_reset();
    advance();
    advance();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_accept_req: got %b expected 1", bus.imem_req); end
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL redir_flush: got v=%b instr=%h expected v=0 instr=0", ifid_valid, ifid_instr); end
    checks++; if (bus.imem_addr !== 32'h40 || bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_addr: got addr=%h req=%b expected addr=40 req=1", bus.imem_addr, bus.imem_req); end
    advance();
    ei = mem_word(32'h40);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h44 || ifid_instr !== ei) begin errors++; $display("[TB] FAIL redir_target: got v=%b pc4=%h instr=%h expected v=1 pc4=44 instr=%h", ifid_valid, ifid_pc4, ifid_instr, ei); end
  endtask

  // Reset while BLOCKED (skid full when present) restores reset state.
  task automatic test_reset_mid();
    logic [31:0] ei;
    do_reset();
    advance();
    advance();
    advance();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    advance();
    advance();
    advance();
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_blocked_req: got %b expected 0", bus.imem_req); end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    advance();
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h0 || bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_bus: got addr=%h req=%b expected addr=0 req=0", bus.imem_addr, bus.imem_req); end
    checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_reset_ifid: got v=%b instr=%h pc4=%h expected all 0", ifid_valid, ifid_instr, ifid_pc4); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    advance();
    advance();
    ei = mem_word(32'h0);
    @(negedge clk);
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h4 || ifid_instr !== ei) begin errors++; $display("[TB] FAIL mid_skid_empty: got v=%b pc4=%h instr=%h expected v=1 pc4=4 instr=%h", ifid_valid, ifid_pc4, ifid_instr, ei); end
  endtask

  // PC wraps from FFFF_FFFC to 0; redirect low bits are dropped.
  task automatic test_wrap();
    logic [31:0] ei;
    do_reset();
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE);
    advance();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_align: got %h expected fffffffc", bus.imem_addr); end
    advance();
    ei = mem_word(32'hFFFF_FFFC);
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_addr: got %h expected 0", bus.imem_addr); end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc4 !== 32'h0 || ifid_instr !== ei) begin errors++; $display("[TB] FAIL wrap_ifid: got v=%b pc4=%h instr=%h expected v=1 pc4=0 instr=%h", ifid_valid, ifid_pc4, ifid_instr, ei); end
  endtask

  // Randomized traffic against the behavioural model.
  task automatic test_random();
    logic [31:0] rpc;
    logic [5:0]  eop;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), rpc);
      @(negedge clk);
      eop = m_instr[31:26];
      checks++; if (bus.imem_req !== model_req()) begin errors++; $display("[TB] FAIL rnd_req: cycle %0d got %b expected %b", n, bus.imem_req, model_req()); end
      checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_addr: cycle %0d got %h expected %h", n, bus.imem_addr, m_pc); end
      checks++; if (ifid_valid !== m_v) begin errors++; $display("[TB] FAIL rnd_valid: cycle %0d got %b expected %b", n, ifid_valid, m_v); end
      checks++; if (ifid_instr !== m_instr) begin errors++; $display("[TB] FAIL rnd_instr: cycle %0d got %h expected %h", n, ifid_instr, m_instr); end
      checks++; if (ifid_pc4 !== m_pc4) begin errors++; $display("[TB] FAIL rnd_pc4: cycle %0d got %h expected %h", n, ifid_pc4, m_pc4); end
      checks++; if (ifid_opcode !== eop) begin errors++; $display("[TB] FAIL rnd_opcode: cycle %0d got %h expected %h", n, ifid_opcode, eop); end
      advance();
    end
  endtask

  // Run every scenario in turn, then report.
  initial begin
    $display("[TB] if_fetch_stage bench starting");
    test_reset();
    test_sequential();
    test_ready_low();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the MIPS pipeline: holds the PC, issues word fetches to instruction memory over a req/ready handshake, and loads the IF/ID pipeline register. The decoded-opcode field it exposes feeds the single-cycle control decoder in ID. Downstream blocks drive it with a hazard stall and a branch/jump redirect.

## Interface
- PC_RESET, 32'h0000_0000, PC value loaded on reset
- clk  in  1  rising-edge clock, sole clock
- rst  in  1  synchronous, active-high reset
- imem_addr  out  32  fetch address (current PC)
- imem_req  out  1  fetch request
- imem_ready  in  1  memory accepts the request; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction word
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  taken branch/jump: flush and refetch
- redirect_pc  in  32  new PC for redirect
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_instr  out  32  IF/ID instruction (32'h0 when invalid)
- ifid_pc4  out  32  IF/ID PC+4
- ifid_opcode  out  6  ifid_instr[31:26], to control decoder

## Operation
- States: BOOT, FETCH, BLOCKED.
- BOOT: entered on rst. imem_req=0. Next cycle → FETCH.
- FETCH: imem_req=1, imem_addr=pc. Accept = imem_req & imem_ready.
  - Accept & !stall: IF/ID ← {1, imem_rdata, pc+4}; pc ← pc+4.
  - !Accept & !stall: IF/ID valid ← 0 (bubble); pc held; imem_addr held stable.
  - stall & ifid_valid: → BLOCKED (without skid, req deasserted the same cycle — req is combinationally gated by stall).
- BLOCKED: imem_req=0, IF/ID and pc held. stall low → FETCH.
- stall with ifid_valid=0: IF/ID stays empty; fetch continues.
- redirect: top priority in every state except BOOT/reset. pc ← redirect_pc; IF/ID valid ← 0, instr ← 0; skid cleared; any word accepted that cycle is discarded; next state FETCH. Redirect overrides stall.
- rst overrides everything, including redirect.
- Invalid IF/ID always presents instr=32'h0 (NOP, opcode 0); downstream must gate write enables with ifid_valid.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC → 32'h0000_0000 silently. Low two bits of redirect_pc are forced to 0.

## Timing
- Reset values (cycle after rst high): pc=PC_RESET, imem_req=0, imem_addr=PC_RESET, ifid_valid=0, ifid_instr=0, ifid_pc4=0, ifid_opcode=0, state=BOOT.
- First request: 1 cycle after rst deasserts. First valid IF/ID: 1 cycle after first accept.
- Fetch-to-IF/ID latency: 1 cycle. Throughput: 1 instr/cycle with imem_ready held high.
- Redirect-to-request: the request at redirect_pc is issued the cycle after redirect; its IF/ID entry is valid the cycle after it is accepted (2 cycles minimum). Exactly one bubble.
- imem_addr changes only on accept, redirect, or reset.

## Configuration
- IF_SKID_EN defined: a one-entry skid buffer is added. During stall, FETCH keeps imem_req high; an accepted word goes into the skid, and pc advances. Req drops (→ BLOCKED) only once the skid is full. On stall release, the skid drains into IF/ID that same edge, and fetch resumes without a bubble.
- IF_SKID_EN undefined: no skid, and stall deasserts req combinationally as described above. Resume costs one bubble cycle.

## Structure
- Shared package mips_pkg: NOP_INSTR (32'h0), PC_STEP (4), OPCODE_MSB/LSB (31/26), the fetch-state enum.
- Sub-module if_skid_buf (one-entry {valid, instr, pc4} buffer with load/drain/clear). It is instantiated only under IF_SKID_EN.

## Test plan
- Reset then imem_ready=1 constantly, PC_RESET=0: imem_addr 0,4,8,… on successive cycles; ifid_pc4=4 with ifid_valid=1 two cycles after rst falls.
- imem_ready low for 3 cycles at addr 8: imem_addr stays 8; ifid_valid=0 for 3 cycles; then instr@8 appears with ifid_pc4=12.
- stall for 2 cycles while IF/ID holds instr@4: IF/ID unchanged. Without skid, req=0 and the next IF/ID after release is a bubble, then instr@8. With IF_SKID_EN, instr@8 appears the cycle after release with no bubble.
- redirect=1, redirect_pc=32'h40 concurrently with stall=1 and a same-cycle accept: accepted word discarded; ifid_valid=0, ifid_instr=0; next imem_addr=32'h40.
- rst asserted mid-stream, including in BLOCKED with a full skid: next cycle all outputs at reset values and the skid is empty.
- pc=32'hFFFF_FFFC accepted: next imem_addr=0, ifid_pc4=0.
